// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and default operand/digit sizes
package serial_adder_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: DIGIT-bit ripple of full-adder cells; a/b/ci in, s sum, co carry-out, cmsb carry into MSB
module digit_adder
  import serial_adder_pkg::*;
#(
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cmsb
);
  logic [DIGIT:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co   = c[DIGIT];
  assign cmsb = c[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial add/sub; in_valid/in_ready + a,b,cin,sub in, out_valid/out_ready + sum,cout,ovf out
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  if (WIDTH % DIGIT != 0 || NDIG < 1) begin : g_chk
    $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
  end
  state_t state;
  logic [WIDTH-1:0] op_a, op_b, nxt_a;
  logic [CW-1:0] cnt;
  logic carry, d_co, d_cmsb, last;
  logic [DIGIT-1:0] d_s;
  digit_adder #(.DIGIT(DIGIT)) u_dig (
    .a(op_a[DIGIT-1:0]),
    .b(op_b[DIGIT-1:0]),
    .ci(carry),
    .s(d_s),
    .co(d_co),
    .cmsb(d_cmsb)
  );
  // op_a shifts out digits at the bottom while result digits enter at the top,
  // so after NDIG digits it holds the complete result in place.
  assign nxt_a = WIDTH'({d_s, op_a} >> DIGIT);
  assign last = cnt == CW'(NDIG - 1);
  assign in_ready = state == S_IDLE;
  assign out_valid = state == S_DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_a  <= '0;
      op_b  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          op_a  <= a;
          op_b  <= sub ? ~b : b;
          carry <= sub ? 1'b1 : cin;
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          op_a  <= nxt_a;
          op_b  <= op_b >> DIGIT;
          carry <= d_co;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum   <= nxt_a;
            cout  <= d_co;
            ovf   <= d_cmsb ^ d_co;
            state <= S_DONE;
          end
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
